fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage LC-3b pipeline. It owns the PC, drives the instruction-cache read handshake, and feeds the IF/ID interstage register with a fetched instruction plus its PC+2. Each cycle it tells IF/ID whether to load, hold, or be squashed, covering cache misses, downstream stalls and control-flow redirects from later stages.

---
 rtl/lc3b_types.sv | 15 +
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // Fetch-stage FSM states, exported so benches can name them.
    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD
    } lc3b_fetch_state;

    localparam lc3b_word PC_STEP = 16'd2;

endpackage

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, runs the icache read handshake
// and steers the IF/ID register (load / hold / squash).
module fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     stall,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    input  logic     icache_resp,
    input  lc3b_word icache_rdata,
    output logic     icache_read,
    output lc3b_word icache_address,
    output lc3b_word instruction,
    output lc3b_word pc_plus2_out,
    output logic     ifid_load,
    output logic     ifid_squash
);

    lc3b_fetch_state state_q, state_d;
    lc3b_word        pc_q, pc_d;
    lc3b_word        hold_buf_q, hold_buf_d;
    lc3b_word        pending_pc_q, pending_pc_d;
    lc3b_word        pc_next_seq;

    assign pc_next_seq    = pc_q + PC_STEP;
    assign icache_address = pc_q;

    // Next-state and IF/ID control; redirect outranks stall, which outranks normal flow.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_buf_d   = hold_buf_q;
        pending_pc_d = pending_pc_q;
        icache_read  = 1'b0;
        instruction  = icache_rdata;
        pc_plus2_out = pc_next_seq;
        ifid_load    = 1'b0;
        ifid_squash  = 1'b0;

        if (reset) begin
            instruction  = '0;
            pc_plus2_out = RESET_PC + PC_STEP;
            ifid_squash  = 1'b1;
        end else begin
            unique case (state_q)
                FETCH: begin
                    icache_read = 1'b1;
                    if (redirect) begin
                        ifid_squash = 1'b1;
                        if (icache_resp) begin
                            pc_d = redirect_pc;
                        end else begin
                            // Miss still in flight: keep the address stable until it returns.
                            pending_pc_d = redirect_pc;
                            state_d      = DISCARD;
                        end
                    end else if (icache_resp) begin
                        if (stall) begin
                            hold_buf_d = icache_rdata;
                            state_d    = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                            pc_d      = pc_next_seq;
                        end
                    end else if (!stall) begin
                        ifid_squash = 1'b1;
                    end
                end

                HOLD: begin
                    instruction = hold_buf_q;
                    if (redirect) begin
                        ifid_squash = 1'b1;
                        pc_d        = redirect_pc;
                        state_d     = FETCH;
                    end else if (!stall) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_next_seq;
                        state_d   = FETCH;
                    end
                end

                DISCARD: begin
                    icache_read = 1'b1;
                    ifid_squash = redirect || !stall;
                    if (icache_resp) begin
                        // Response belongs to the flushed path; drop it.
                        pc_d    = redirect ? redirect_pc : pending_pc_q;
                        state_d = FETCH;
                    end else if (redirect) begin
                        pending_pc_d = redirect_pc;
                    end
                end

                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            hold_buf_q   <= '0;
            pending_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_buf_q   <= hold_buf_d;
            pending_pc_q <= pending_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a cycle-level reference model.
module tb_fetch_stage;

    localparam logic [15:0] RP = 16'h0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        icache_resp;
    logic [15:0] icache_rdata;
    logic        icache_read;
    logic [15:0] icache_address;
    logic [15:0] instruction;
    logic [15:0] pc_plus2_out;
    logic        ifid_load;
    logic        ifid_squash;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage #(.RESET_PC(RP)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .icache_resp   (icache_resp),
        .icache_rdata  (icache_rdata),
        .icache_read   (icache_read),
        .icache_address(icache_address),
        .instruction   (instruction),
        .pc_plus2_out  (pc_plus2_out),
        .ifid_load     (ifid_load),
        .ifid_squash   (ifid_squash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the PC, whether a stalled word is parked, and whether an
    // abandoned miss is still outstanding together with where to go afterwards.
    logic [15:0] m_pc, m_buf, m_tgt;
    bit          m_hold, m_disc, m_live = 1'b0;
    logic [15:0] n_pc, n_buf, n_tgt;
    bit          n_hold, n_disc;
    logic        e_load, e_squash;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_read", icache_read, 1'b0);
            check("rst_load", ifid_load, 1'b0);
            check("rst_squash", ifid_squash, 1'b1);
            check("rst_instr", instruction, 16'h0000);
            check("rst_pc2", pc_plus2_out, RP + 16'd2);
            n_pc = RP; n_buf = '0; n_tgt = '0; n_hold = 0; n_disc = 0;
        end else if (m_live) begin
            e_load   = !redirect && !m_disc && !stall && (m_hold || icache_resp);
            e_squash = redirect || (m_disc && !stall)
                       || (!m_hold && !m_disc && !icache_resp && !stall);
            check("read", icache_read, !m_hold);
            check("addr", icache_address, m_pc);
            check("pc2", pc_plus2_out, m_pc + 16'd2);
            check("load", ifid_load, e_load);
            check("squash", ifid_squash, e_squash);
            check("excl", ifid_load & ifid_squash, 1'b0);
            if (m_hold) check("instr_buf", instruction, m_buf);
            else if (!m_disc) check("instr", instruction, icache_rdata);

            n_pc = m_pc; n_buf = m_buf; n_tgt = m_tgt; n_hold = m_hold; n_disc = m_disc;
            if (m_disc) begin
                if (icache_resp) begin
                    n_pc   = redirect ? redirect_pc : m_tgt;
                    n_disc = 0;
                end else if (redirect) begin
                    n_tgt = redirect_pc;
                end
            end else if (m_hold) begin
                if (redirect) begin
                    n_pc = redirect_pc; n_hold = 0;
                end else if (!stall) begin
                    n_pc = m_pc + 16'd2; n_hold = 0;
                end
            end else if (redirect) begin
                if (icache_resp) n_pc = redirect_pc;
                else begin
                    n_disc = 1; n_tgt = redirect_pc;
                end
            end else if (icache_resp) begin
                if (stall) begin
                    n_hold = 1; n_buf = icache_rdata;
                end else begin
                    n_pc = m_pc + 16'd2;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) m_live = 1'b1;
        m_pc = n_pc; m_buf = n_buf; m_tgt = n_tgt; m_hold = n_hold; m_disc = n_disc;
    end

    // Apply one cycle of inputs shortly after the edge; returns with outputs settled.
    task automatic step(input logic r, input logic st, input logic rd, input logic [15:0] rpc,
                        input logic rsp, input logic [15:0] rdat);
        @(posedge clk);
        #1;
        reset = r; stall = st; redirect = rd; redirect_pc = rpc;
        icache_resp = rsp; icache_rdata = rdat;
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        icache_resp = 1'b0; icache_rdata = '0;

        // Reset
        repeat (2) begin
            step(1, 0, 0, 16'h0, 0, 16'h0);
            check("lit_rst_pc2", pc_plus2_out, 16'h0002);
            check("lit_rst_squash", ifid_squash, 1'b1);
        end

        // Back-to-back hits from RESET_PC
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 16'h0, 1, 16'h1000 + 16'(i));
            check("lit_hit_addr", icache_address, 16'(2 * i));
            check("lit_hit_pc2", pc_plus2_out, 16'(2 * i + 2));
            check("lit_hit_load", ifid_load, 1'b1);
        end

        // Three-cycle miss at 0x0010
        step(0, 0, 1, 16'h0010, 1, 16'hbeef);
        check("lit_redir_squash", ifid_squash, 1'b1);
        repeat (3) begin
            step(0, 0, 0, 16'h0, 0, 16'h0);
            check("lit_miss_addr", icache_address, 16'h0010);
            check("lit_miss_squash", ifid_squash, 1'b1);
        end
        step(0, 0, 0, 16'h0, 1, 16'h2010);
        check("lit_miss_load", ifid_load, 1'b1);
        check("lit_miss_pc2", pc_plus2_out, 16'h0012);

        // Hit at 0x0020 under a four-cycle stall
        step(0, 0, 1, 16'h0020, 1, 16'h1111);
        step(0, 1, 0, 16'h0, 1, 16'h2020);
        check("lit_stall_addr", icache_address, 16'h0020);
        check("lit_stall_load", ifid_load, 1'b0);
        repeat (3) begin
            step(0, 1, 0, 16'h0, 0, 16'h5555);
            check("lit_hold_read", icache_read, 1'b0);
            check("lit_hold_instr", instruction, 16'h2020);
        end
        step(0, 0, 0, 16'h0, 0, 16'h5555);
        check("lit_release_load", ifid_load, 1'b1);
        check("lit_release_instr", instruction, 16'h2020);
        step(0, 0, 0, 16'h0, 1, 16'h2022);
        check("lit_after_hold_addr", icache_address, 16'h0022);

        // Redirect while a miss is outstanding at 0x0030
        step(0, 0, 1, 16'h0030, 1, 16'h1212);
        step(0, 0, 1, 16'h0100, 0, 16'h0);
        check("lit_disc_addr0", icache_address, 16'h0030);
        repeat (2) begin
            step(0, 0, 0, 16'h0, 0, 16'h0);
            check("lit_disc_addr", icache_address, 16'h0030);
            check("lit_disc_squash", ifid_squash, 1'b1);
        end
        step(0, 0, 0, 16'h0, 1, 16'hdead);
        check("lit_disc_drop", ifid_load, 1'b0);
        step(0, 0, 0, 16'h0, 0, 16'h0);
        check("lit_disc_target", icache_address, 16'h0100);

        // Repeated redirects in DISCARD, one under stall
        step(0, 0, 1, 16'h0200, 0, 16'h0);
        step(0, 1, 1, 16'h0300, 0, 16'h0);
        check("lit_stall_redir_squash", ifid_squash, 1'b1);
        step(0, 1, 0, 16'h0, 0, 16'h0);
        check("lit_disc_stall_squash", ifid_squash, 1'b0);
        step(0, 0, 0, 16'h0, 1, 16'hdead);
        step(0, 0, 1, 16'hfffe, 1, 16'h3000);
        check("lit_latest_wins", icache_address, 16'h0300);

        // PC wrap at 0xFFFE
        step(0, 0, 0, 16'h0, 1, 16'h7777);
        check("lit_wrap_addr", icache_address, 16'hfffe);
        check("lit_wrap_pc2", pc_plus2_out, 16'h0000);
        step(0, 0, 1, 16'h0040, 1, 16'h0);
        check("lit_wrap_next", icache_address, 16'h0000);

        // Reset during a miss at 0x0040
        step(0, 0, 0, 16'h0, 0, 16'h0);
        check("lit_miss40_addr", icache_address, 16'h0040);
        step(0, 1, 0, 16'h0, 0, 16'h0);
        step(1, 0, 0, 16'h0, 0, 16'h0);
        step(0, 0, 0, 16'h0, 1, 16'h4444);
        check("lit_post_rst_addr", icache_address, RP);
        check("lit_post_rst_load", ifid_load, 1'b1);
        step(0, 0, 0, 16'h0, 0, 16'h0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
